// File: rtl/fib_engine_if.sv
// Request/response bundle for fib_engine: index request in, F(n) plus overflow flag out.
// Both directions use valid/ready; busy is status only.
interface fib_engine_if #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 6
);
   logic             req_valid;
   logic             req_ready;
   logic [IDX_W-1:0] req_index;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_value;
   logic             rsp_overflow;
   logic             busy;

   modport slave (
      input  req_valid, req_index, rsp_ready,
      output req_ready, rsp_valid, rsp_value, rsp_overflow, busy
   );

   modport master (
      output req_valid, req_index, rsp_ready,
      input  req_ready, rsp_valid, rsp_value, rsp_overflow, busy
   );
endinterface

// File: rtl/fib_engine.sv
// Iterative Fibonacci engine: F(n) mod 2^WIDTH with a sticky overflow flag, one term per cycle.
// Latency n+1 cycles from accept to rsp_valid; result held in HOLD until rsp_ready, no request accepted meanwhile.
module fib_engine #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 6
) (
   input  logic         clock,
   input  logic         reset,
   fib_engine_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state, state_nxt;
   logic             rdy_q;
   logic [WIDTH-1:0] prev, curr, value_q;
   logic             ovf_prev, ovf_curr, ovf_q;
   logic [IDX_W-1:0] cnt, n_reg;
   logic [WIDTH:0]   sum;
   logic             accept, last;

   assign accept = bus.req_valid && rdy_q;
   assign last   = (cnt == n_reg);
   assign sum    = {1'b0, curr} + {1'b0, prev};

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (last) state_nxt = HOLD;
         HOLD:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // req_ready is registered so it stays low while reset is held
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         rdy_q <= 1'b0;
      end else begin
         state <= state_nxt;
         rdy_q <= (state_nxt == IDLE);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev     <= '0;
         curr     <= '0;
         ovf_prev <= 1'b0;
         ovf_curr <= 1'b0;
         cnt      <= '0;
         n_reg    <= '0;
         value_q  <= '0;
         ovf_q    <= 1'b0;
      end else if (state == IDLE) begin
         if (accept) begin
            n_reg    <= bus.req_index;
            prev     <= '0;
            curr     <= WIDTH'(1);
            ovf_prev <= 1'b0;
            ovf_curr <= 1'b0;
            cnt      <= '0;
         end
      end else if (state == RUN) begin
         if (last) begin
            value_q <= prev;
            ovf_q   <= ovf_prev;
         end else begin
            prev     <= curr;
            curr     <= sum[WIDTH-1:0];
            ovf_prev <= ovf_curr;
            // overflow is sticky: a wrapped term taints every later term
            ovf_curr <= ovf_curr | ovf_prev | sum[WIDTH];
            cnt      <= cnt + IDX_W'(1);
         end
      end
   end

   assign bus.req_ready    = rdy_q;
   assign bus.rsp_valid    = (state == HOLD);
   assign bus.rsp_value    = value_q;
   assign bus.rsp_overflow = ovf_q;
   assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_fib_engine.sv
// Directed bench for fib_engine: 32-bit and 8-bit instances, expected values hand-computed.
module tb_fib_engine;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   fib_engine_if #(.WIDTH(32), .IDX_W(6)) b32 ();
   fib_engine_if #(.WIDTH(8),  .IDX_W(6)) b8 ();

   fib_engine #(.WIDTH(32), .IDX_W(6)) u32 (.clock(clock), .reset(reset), .bus(b32));
   fib_engine #(.WIDTH(8),  .IDX_W(6)) u8  (.clock(clock), .reset(reset), .bus(b8));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue one request on the 32-bit engine; returns cycles spent waiting for req_ready.
   task automatic run32(input string tag, input int n, input logic [31:0] ev, input logic eo,
                        output int waited);
      int lat;
      logic busy_ok;
      waited = 0;
      while (b32.req_ready !== 1'b1 && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      b32.req_valid = 1'b1;
      b32.req_index = 6'(n);
      @(posedge clock);
      @(negedge clock);
      b32.req_valid = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      while (b32.rsp_valid !== 1'b1 && lat < 200) begin
         if (b32.busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clock);
         lat++;
      end
      chk({tag, ".latency"}, 64'(lat), 64'(n + 1));
      chk({tag, ".value"}, 64'(b32.rsp_value), 64'(ev));
      chk({tag, ".overflow"}, 64'(b32.rsp_overflow), 64'(eo));
      chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
   endtask

   task automatic run8(input string tag, input int n, input logic [7:0] ev, input logic eo);
      int lat;
      int waited;
      waited = 0;
      while (b8.req_ready !== 1'b1 && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      b8.req_valid = 1'b1;
      b8.req_index = 6'(n);
      @(posedge clock);
      @(negedge clock);
      b8.req_valid = 1'b0;
      lat = 0;
      while (b8.rsp_valid !== 1'b1 && lat < 200) begin
         @(negedge clock);
         lat++;
      end
      chk({tag, ".latency"}, 64'(lat), 64'(n + 1));
      chk({tag, ".value"}, 64'(b8.rsp_value), 64'(ev));
      chk({tag, ".overflow"}, 64'(b8.rsp_overflow), 64'(eo));
   endtask

   initial begin
      int w;
      b32.req_valid = 1'b0; b32.req_index = '0; b32.rsp_ready = 1'b1;
      b8.req_valid  = 1'b0; b8.req_index  = '0; b8.rsp_ready  = 1'b1;

      // reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset.req_ready", 64'(b32.req_ready), 64'd0);
      chk("reset.rsp_valid", 64'(b32.rsp_valid), 64'd0);
      chk("reset.rsp_value", 64'(b32.rsp_value), 64'd0);
      chk("reset.rsp_overflow", 64'(b32.rsp_overflow), 64'd0);
      chk("reset.busy", 64'(b32.busy), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("post_reset.req_ready", 64'(b32.req_ready), 64'd1);

      // small indices and nominal
      run32("n0", 0, 32'd0, 1'b0, w);
      run32("n1", 1, 32'd1, 1'b0, w);
      run32("n10", 10, 32'd55, 1'b0, w);

      // 32-bit overflow boundary
      run32("n47", 47, 32'd2971215073, 1'b0, w);
      run32("n48", 48, 32'd512559680, 1'b1, w);
      run32("n63", 63, 32'd3350226146, 1'b1, w);

      // 8-bit overflow boundary
      run8("w8_n12", 12, 8'd144, 1'b0);
      run8("w8_n13", 13, 8'd233, 1'b0);
      run8("w8_n14", 14, 8'd121, 1'b1);

      // backpressure in HOLD, with a request pulse that must be ignored
      b32.rsp_ready = 1'b0;
      run32("bp_n20", 20, 32'd6765, 1'b0, w);
      for (int i = 0; i < 5; i++) begin
         b32.req_valid = (i == 2);
         b32.req_index = 6'd3;
         @(negedge clock);
         chk($sformatf("bp.value[%0d]", i), 64'(b32.rsp_value), 64'd6765);
         chk($sformatf("bp.rsp_valid[%0d]", i), 64'(b32.rsp_valid), 64'd1);
         chk($sformatf("bp.req_ready[%0d]", i), 64'(b32.req_ready), 64'd0);
      end
      b32.req_valid = 1'b0;
      b32.rsp_ready = 1'b1;
      @(negedge clock);
      chk("bp.release_rsp_valid", 64'(b32.rsp_valid), 64'd0);
      chk("bp.release_req_ready", 64'(b32.req_ready), 64'd1);
      chk("bp.release_busy", 64'(b32.busy), 64'd0);
      run32("bp_next_n2", 2, 32'd1, 1'b0, w);
      chk("bp_next.accept_wait", 64'(w), 64'd0);

      // reset four cycles into RUN discards the in-flight result
      @(negedge clock);
      b32.req_valid = 1'b1;
      b32.req_index = 6'd30;
      @(posedge clock);
      @(negedge clock);
      b32.req_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("midrun.busy_before", 64'(b32.busy), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      chk("midrun.busy", 64'(b32.busy), 64'd0);
      chk("midrun.rsp_valid", 64'(b32.rsp_valid), 64'd0);
      chk("midrun.rsp_value", 64'(b32.rsp_value), 64'd0);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         chk("midrun.no_rsp", 64'(b32.rsp_valid), 64'd0);
      end
      run32("after_reset_n5", 5, 32'd5, 1'b0, w);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fib_engine.md
# fib_engine

Parametrised, handshaked Fibonacci engine, the next generation of the free-running fixed-32-bit `fibonacci` counter. It accepts an index n on a valid/ready request port and iteratively computes F(n), with F(0)=0 and F(1)=1. It returns F(n) modulo 2^WIDTH with an overflow flag on a valid/ready response port. It sits as a slave compute unit behind any controller that issues index requests.

## Interface
- `WIDTH`, default 32: width of datapath and result (≥2).
- `IDX_W`, default 6: width of requested index; max n = 2^IDX_W−1.

Ports:
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  engine can accept a request.
- `req_index`  in  IDX_W  index n, sampled on request handshake.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_value`  out  WIDTH  F(n) mod 2^WIDTH.
- `rsp_overflow`  out  1  true F(n) ≥ 2^WIDTH.
- `busy`  out  1  high in RUN or HOLD.

## Operation
- Internal state: `prev`/`curr` (WIDTH), `ovf_prev`/`ovf_curr` (1), `cnt`/`n_reg` (IDX_W), FSM {IDLE, RUN, HOLD}.
- IDLE:
  - Output `req_ready`=1.
  - On `req_valid`&&`req_ready`: `n_reg`←`req_index`, `prev`←0, `curr`←1, `ovf_prev`←0, `ovf_curr`←0, `cnt`←0, go to RUN.
- RUN (one step per cycle):
  - If `cnt`==`n_reg`:
    - `rsp_value`←`prev`, `rsp_overflow`←`ovf_prev`.
    - Go to HOLD.
  - Else:
    - `prev`←`curr`.
    - `curr`←(`curr`+`prev`) mod 2^WIDTH.
    - `ovf_prev`←`ovf_curr`.
    - `ovf_curr`←`ovf_curr`|`ovf_prev`|carry-out of the WIDTH-bit add.
    - `cnt`←`cnt`+1.
- Overflow rule: the flag is sticky per term, so wrapped terms propagate overflow to every later term. `curr` may overflow one step before `prev` does; only `ovf_prev` is reported.
- Width rule: `cnt` never wraps, because the comparison against `n_reg` terminates at n ≤ 2^IDX_W−1.
- HOLD:
  - `rsp_valid`=1.
  - `rsp_value`/`rsp_overflow` held stable until `rsp_ready`=1.
  - On handshake, go to IDLE.
- `req_ready`=0 in RUN and HOLD; `req_valid` there is ignored, not queued.
- `rsp_ready` outside HOLD is ignored.

## Timing
- Reset values:
  - FSM=IDLE.
  - `req_ready`=1 after the reset cycle; 0 during the cycle `reset` is high.
  - `rsp_valid`=0, `rsp_value`=0, `rsp_overflow`=0, `busy`=0.
  - Internal registers 0.
- Reset has priority over every other event, including mid-RUN and mid-HOLD. An in-flight result is discarded with no `rsp_valid` pulse.
- Latency: request handshake at edge t0 → `rsp_valid` high after edge t0+n+1. For example, n=0 gives 1 cycle and n=63 gives 64 cycles.
- Throughput:
  - With `rsp_ready` tied high: one result per n+3 cycles (IDLE, RUN×(n+1), HOLD).
  - `rsp_valid`&&`rsp_ready` in HOLD at edge t → `req_ready` high after t, so the next request is accepted at edge t+1 at earliest.
- All outputs are registered or decoded from FSM state only; there is no combinational path from inputs to outputs.

## Test plan
- Index 0 / index 1: `req_index`=0 → `rsp_value`=0, `rsp_overflow`=0, `rsp_valid` 1 cycle after accept. Then `req_index`=1 → 1, 2 cycles after accept.
- Nominal and latency: `req_index`=10, `rsp_ready`=1 → `rsp_value`=55, `rsp_overflow`=0, `rsp_valid` exactly 11 cycles after accept, `busy` high throughout.
- Overflow boundary, WIDTH=32:
  - n=47 → 2971215073, `rsp_overflow`=0.
  - n=48 → 512559680, `rsp_overflow`=1.
  - n=63 → `rsp_overflow`=1.
- Overflow boundary, WIDTH=8:
  - n=13 → 233, `rsp_overflow`=0.
  - n=14 → 121, `rsp_overflow`=1.
- Backpressure: n=20 with `rsp_ready`=0 for 5 cycles in HOLD → `rsp_value`=6765 stable, `req_ready`=0. A `req_valid` pulse during HOLD is not accepted. After `rsp_ready`=1, the next request is accepted 1 cycle later.
- Reset mid-operation: `reset` asserted 4 cycles into RUN for n=30 → next cycle FSM IDLE, `rsp_valid`=0, `busy`=0, `rsp_value`=0. A new request n=5 then returns 5.
